// File: rtl/pp_accum_if.sv
// Stream bundle between the add2 combiner and pp_accum: partial sums in, finished products out.
// Master is the side that feeds partial sums and consumes products; slave is the accumulator.
interface pp_accum_if #(
    parameter int SW = 185,
    parameter int RW = 334
);
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] res;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, res
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, res
    );
endinterface

// File: rtl/pp_accum.sv
// Sequential partial-product accumulator: K beats of SW-bit sums, beat i weighted by 2^(i*DW).
// Each non-final beat retires DW low bits into res, so the adder is only AW bits wide.
module pp_accum #(
    parameter int N = 222,
    parameter int K = 3,
    localparam int DW = N / 3,
    localparam int SW = 5 * N / 6,
    localparam int AW = SW + 1,
    localparam int RW = (K - 1) * DW + AW,
    localparam int CW = $clog2(K)
) (
    input  logic       clk,
    input  logic       rst,
    pp_accum_if.slave  s,
    output logic       busy
);

    if ((N % 6 != 0) || (K < 2)) begin : g_param_check
        $error("pp_accum: N must be a multiple of 6 and K must be at least 2");
    end

    typedef enum logic [0:0] {ACC, OUT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [RW-1:0] res_q;
    logic          in_xfer;
    logic          last;

    assign in_xfer = s.in_valid && (state == ACC);
    assign last    = (cnt == CW'(K - 1));
    // acc never exceeds AW-DW bits after a shift, so this add cannot overflow AW
    assign sum     = acc + AW'(s.in_data);

    always_ff @(posedge clk) begin
        if (rst) state <= ACC;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        s.in_ready  = 1'b0;
        s.out_valid = 1'b0;
        case (state)
            ACC: begin
                s.in_ready = 1'b1;
                if (in_xfer && last) state_nx = OUT;
            end
            OUT: begin
                s.out_valid = 1'b1;
                if (s.out_ready) state_nx = ACC;
            end
            default: state_nx = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            res_q <= '0;
        end else if (in_xfer) begin
            if (!last) begin
                res_q[cnt*DW +: DW] <= sum[DW-1:0];
                acc                 <= sum >> DW;
                cnt                 <= cnt + CW'(1);
            end else begin
                res_q[RW-1 -: AW] <= sum;
                acc               <= '0;
                cnt               <= '0;
            end
        end
    end

    assign s.res = res_q;
    assign busy  = (cnt != '0) || (state == OUT);

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (rst)
        !(s.in_ready && s.out_valid));

    a_res_hold: assert property (@(posedge clk) disable iff (rst)
        (state == OUT && !s.out_ready) |=> $stable(res_q));

    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        cnt <= CW'(K - 1));

endmodule
